// File: rtl/tap_loader_pkg.sv
// rtl/tap_loader_pkg.sv - shared types and constants for the .TAP image parser
package tap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR,
    NAME,
    DATA,
    DONE,
    ERR
  } tap_state_t;

  localparam logic [7:0] TAP_SYNC    = 8'h16;
  localparam logic [7:0] TAP_MARK    = 8'h24;
  localparam int         TAP_HDR_LEN = 9;

  // Byte positions inside the 9-byte header that follows the marker
  localparam logic [3:0] HDR_TYPE     = 4'd2;
  localparam logic [3:0] HDR_AUTORUN  = 4'd3;
  localparam logic [3:0] HDR_END_HI   = 4'd4;
  localparam logic [3:0] HDR_END_LO   = 4'd5;
  localparam logic [3:0] HDR_START_HI = 4'd6;
  localparam logic [3:0] HDR_START_LO = 4'd7;

endpackage

// File: rtl/tap_loader.sv
// rtl/tap_loader.sv - streams the first file of an Oric .TAP image into RAM
module tap_loader
  import tap_pkg::*;
#(
  parameter int MIN_SYNC = 3,
  parameter int MAX_NAME = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] tape_addr,
  output logic [7:0]  tape_dout,
  output logic        tape_wr,
  output logic [15:0] loadpoint,
  output logic        tape_autorun,
  output logic        tape_type,
  output logic        tape_complete,
  output logic        tape_error
);

  localparam int NW = $clog2(MAX_NAME + 1);

  tap_state_t    state, state_next, cur;
  logic [2:0]    sync_cnt, sync_next;
  logic [3:0]    hdr_idx, hdr_idx_next;
  logic [NW-1:0] name_cnt, name_next;
  logic [15:0]   start_addr, start_next, end_addr, end_next, wptr, wptr_next;
  logic          hdr_type, hdr_type_next, hdr_auto, hdr_auto_next;
  logic          dl_q, wr_now, accept, restart, fall;

  assign accept  = ioctl_download & ioctl_wr;
  assign restart = accept && (ioctl_addr == '0);
  assign fall    = dl_q & ~ioctl_download;

  always_comb begin
    state_next    = state;
    cur           = state;
    sync_next     = sync_cnt;
    hdr_idx_next  = hdr_idx;
    name_next     = name_cnt;
    start_next    = start_addr;
    end_next      = end_addr;
    wptr_next     = wptr;
    hdr_type_next = hdr_type;
    hdr_auto_next = hdr_auto;
    wr_now        = 1'b0;

    // A restart byte is parsed as if the machine were already in a fresh SYNC
    if (restart) begin
      cur          = SYNC;
      state_next   = SYNC;
      sync_next    = '0;
      hdr_idx_next = '0;
      name_next    = '0;
    end

    if (accept) begin
      case (cur)
        SYNC: begin
          if (ioctl_dout == TAP_SYNC) begin
            sync_next = (sync_next == 3'd7) ? 3'd7 : sync_next + 3'd1;
          end else if (ioctl_dout == TAP_MARK && int'(sync_next) >= MIN_SYNC) begin
            state_next = HDR;
          end else begin
            sync_next = '0;
          end
        end
        HDR: begin
          case (hdr_idx)
            HDR_TYPE:     hdr_type_next = ioctl_dout[7];
            HDR_AUTORUN:  hdr_auto_next = (ioctl_dout != 8'h00);
            HDR_END_HI:   end_next[15:8] = ioctl_dout;
            HDR_END_LO:   end_next[7:0] = ioctl_dout;
            HDR_START_HI: start_next[15:8] = ioctl_dout;
            HDR_START_LO: start_next[7:0] = ioctl_dout;
            default: ;
          endcase
          if (int'(hdr_idx) == TAP_HDR_LEN - 1) begin
            state_next = (end_addr < start_addr) ? ERR : NAME;
          end else begin
            hdr_idx_next = hdr_idx + 4'd1;
          end
        end
        NAME: begin
          if (ioctl_dout == 8'h00) begin
            state_next = DATA;
            wptr_next  = start_addr;
          end else if (name_cnt == NW'(MAX_NAME)) begin
            state_next = ERR;
          end else begin
            name_next = name_cnt + 1'b1;
          end
        end
        DATA: begin
          wr_now = 1'b1;
          // Compare before incrementing so an end address of 0xFFFF never wraps
          if (wptr == end_addr) state_next = DONE;
          else wptr_next = wptr + 16'd1;
        end
        default: ;
      endcase
    end

    if (fall && (state_next inside {SYNC, HDR, NAME, DATA})) state_next = ERR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      sync_cnt      <= '0;
      hdr_idx       <= '0;
      name_cnt      <= '0;
      start_addr    <= '0;
      end_addr      <= '0;
      wptr          <= '0;
      hdr_type      <= 1'b0;
      hdr_auto      <= 1'b0;
      dl_q          <= 1'b0;
      tape_addr     <= '0;
      tape_dout     <= '0;
      tape_wr       <= 1'b0;
      loadpoint     <= '0;
      tape_autorun  <= 1'b0;
      tape_type     <= 1'b0;
      tape_complete <= 1'b0;
      tape_error    <= 1'b0;
    end else begin
      state         <= state_next;
      sync_cnt      <= sync_next;
      hdr_idx       <= hdr_idx_next;
      name_cnt      <= name_next;
      start_addr    <= start_next;
      end_addr      <= end_next;
      wptr          <= wptr_next;
      hdr_type      <= hdr_type_next;
      hdr_auto      <= hdr_auto_next;
      dl_q          <= ioctl_download;
      tape_wr       <= wr_now;
      tape_complete <= (state_next == DONE);
      tape_error    <= (state_next == ERR);
      if (wr_now) begin
        tape_addr <= wptr;
        tape_dout <= ioctl_dout;
      end
      if (restart) begin
        tape_autorun <= 1'b0;
      end else if (state_next == DONE && state != DONE) begin
        tape_autorun <= hdr_auto;
        tape_type    <= hdr_type;
        loadpoint    <= start_addr;
      end
    end
  end

endmodule

// File: tb/tb_tap_loader.sv
// tb/tb_tap_loader.sv - directed scoreboard bench for tap_loader
module tb_tap_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_wr;
  logic [15:0] loadpoint;
  logic        tape_autorun;
  logic        tape_type;
  logic        tape_complete;
  logic        tape_error;

  tap_loader #(.MIN_SYNC(3), .MAX_NAME(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .tape_addr     (tape_addr),
    .tape_dout     (tape_dout),
    .tape_wr       (tape_wr),
    .loadpoint     (loadpoint),
    .tape_autorun  (tape_autorun),
    .tape_type     (tape_type),
    .tape_complete (tape_complete),
    .tape_error    (tape_error)
  );

  always #5 clk = ~clk;

  logic [7:0]  img[$];
  logic [23:0] exp_q[$];
  int          dstart;
  logic [15:0] wbase;
  bit          arm;
  int          checks = 0;
  int          failures = 0;
  int          nwr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    logic [23:0] e;
    @(posedge clk);
    #1;
    if (tape_wr === 1'b1) begin
      nwr++;
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {8'h00, tape_addr, tape_dout}, {8'h00, e});
      end
    end
  endtask

  task automatic build(input logic [15:0] st, input logic [15:0] en, input logic [7:0] typ,
                       input logic [7:0] aut, input int nsync, input int nname, input int ndata);
    img.delete();
    repeat (nsync) img.push_back(8'h16);
    img.push_back(8'h24);
    img.push_back(8'h00); img.push_back(8'h00);
    img.push_back(typ);   img.push_back(aut);
    img.push_back(en[15:8]); img.push_back(en[7:0]);
    img.push_back(st[15:8]); img.push_back(st[7:0]);
    img.push_back(8'h00);
    for (int i = 0; i < nname; i++) img.push_back(8'h41 + 8'(i));
    img.push_back(8'h00);
    dstart = img.size();
    wbase  = st;
    for (int i = 0; i < ndata; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send(input int from, input int to);
    for (int i = from; i < to; i++) begin
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b1;
      ioctl_addr     = 25'(i);
      ioctl_dout     = img[i];
      if (arm && i >= dstart) exp_q.push_back({wbase + 16'(i - dstart), img[i]});
      step();
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic end_img();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step();
    step();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    arm = 1'b1;
    repeat (3) step();
    chk("rst_addr", 32'(tape_addr), 32'h0);
    chk("rst_dout", 32'(tape_dout), 32'h0);
    chk("rst_wr", 32'(tape_wr), 32'h0);
    chk("rst_loadpoint", 32'(loadpoint), 32'h0);
    chk("rst_autorun", 32'(tape_autorun), 32'h0);
    chk("rst_type", 32'(tape_type), 32'h0);
    chk("rst_complete", 32'(tape_complete), 32'h0);
    chk("rst_error", 32'(tape_error), 32'h0);
    reset_n = 1'b1;
    step();

    // Basic load straight from the reference image
    nwr = 0;
    img = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'hC7, 8'h05, 8'h03,
            8'h05, 8'h00, 8'h00, 8'h41, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    dstart = 15; wbase = 16'h0500;
    send(0, 18);
    chk("basic_not_yet_complete", 32'(tape_complete), 32'd0);
    send(18, 19);
    chk("basic_complete_with_last_wr", 32'(tape_complete), 32'd1);
    chk("basic_nwr", 32'(nwr), 32'd4);
    chk("basic_loadpoint", 32'(loadpoint), 32'h0500);
    chk("basic_autorun", 32'(tape_autorun), 32'd1);
    chk("basic_type", 32'(tape_type), 32'd0);
    arm = 1'b0;
    img.push_back(8'h99);
    send(19, 20);
    chk("done_ignores_bytes", 32'(nwr), 32'd4);
    arm = 1'b1;
    end_img();
    chk("basic_hold_complete", 32'(tape_complete), 32'd1);
    chk("basic_no_error", 32'(tape_error), 32'd0);

    // Short sync run: first marker is discarded
    nwr = 0;
    build(16'h1000, 16'h1001, 8'h80, 8'h00, 3, 2, 2);
    img.push_front(8'h24); img.push_front(8'h16); img.push_front(8'h16);
    dstart += 3;
    send(0, img.size());
    end_img();
    chk("short_complete", 32'(tape_complete), 32'd1);
    chk("short_nwr", 32'(nwr), 32'd2);
    chk("short_loadpoint", 32'(loadpoint), 32'h1000);
    chk("short_type", 32'(tape_type), 32'd1);
    chk("short_autorun", 32'(tape_autorun), 32'd0);

    // Header with end below start
    nwr = 0; arm = 1'b0;
    build(16'h0500, 16'h0400, 8'h00, 8'h01, 3, 1, 2);
    send(0, 12);
    chk("badhdr_err_before_b8", 32'(tape_error), 32'd0);
    send(12, 13);
    chk("badhdr_err_after_b8", 32'(tape_error), 32'd1);
    send(13, img.size());
    end_img();
    chk("badhdr_nwr", 32'(nwr), 32'd0);
    chk("badhdr_complete", 32'(tape_complete), 32'd0);
    chk("badhdr_error_held", 32'(tape_error), 32'd1);

    // Seventeen-character name is rejected, sixteen is accepted
    nwr = 0;
    build(16'h2000, 16'h2000, 8'h00, 8'h00, 3, 17, 1);
    send(0, 29);
    chk("longname_ok_at_16", 32'(tape_error), 32'd0);
    send(29, 30);
    chk("longname_err_at_17", 32'(tape_error), 32'd1);
    send(30, img.size());
    end_img();
    chk("longname_nwr", 32'(nwr), 32'd0);
    arm = 1'b1;
    build(16'h2000, 16'h2000, 8'h00, 8'h00, 3, 16, 1);
    send(0, img.size());
    end_img();
    chk("name16_complete", 32'(tape_complete), 32'd1);
    chk("name16_error", 32'(tape_error), 32'd0);
    chk("name16_nwr", 32'(nwr), 32'd1);
    chk("name16_loadpoint", 32'(loadpoint), 32'h2000);

    // Download ends after two of four data bytes
    nwr = 0;
    build(16'h3000, 16'h3003, 8'h00, 8'h00, 3, 1, 4);
    send(0, dstart + 2);
    end_img();
    chk("trunc_nwr", 32'(nwr), 32'd2);
    chk("trunc_error", 32'(tape_error), 32'd1);
    chk("trunc_complete", 32'(tape_complete), 32'd0);

    // New image at offset 0 while still in DATA
    nwr = 0;
    build(16'h4000, 16'h4003, 8'h00, 8'h00, 3, 2, 4);
    send(0, dstart + 2);
    build(16'h4100, 16'h4101, 8'h80, 8'h01, 4, 0, 2);
    send(0, 1);
    chk("restart_clears_error", 32'(tape_error), 32'd0);
    chk("restart_clears_complete", 32'(tape_complete), 32'd0);
    send(1, img.size());
    end_img();
    chk("restart_complete", 32'(tape_complete), 32'd1);
    chk("restart_nwr", 32'(nwr), 32'd4);
    chk("restart_loadpoint", 32'(loadpoint), 32'h4100);
    chk("restart_autorun", 32'(tape_autorun), 32'd1);
    chk("restart_type", 32'(tape_type), 32'd1);

    // Reset in the middle of DATA, with a byte offered in the same cycle
    nwr = 0;
    build(16'h5000, 16'h5003, 8'h80, 8'h01, 3, 1, 4);
    send(0, dstart + 1);
    reset_n = 1'b0; ioctl_download = 1'b1; ioctl_wr = 1'b1;
    ioctl_addr = 25'(dstart + 1); ioctl_dout = img[dstart + 1];
    step();
    chk("rstmid_wr", 32'(tape_wr), 32'd0);
    chk("rstmid_addr", 32'(tape_addr), 32'h0);
    chk("rstmid_dout", 32'(tape_dout), 32'h0);
    chk("rstmid_loadpoint", 32'(loadpoint), 32'h0);
    chk("rstmid_autorun", 32'(tape_autorun), 32'd0);
    chk("rstmid_type", 32'(tape_type), 32'd0);
    chk("rstmid_complete", 32'(tape_complete), 32'd0);
    chk("rstmid_error", 32'(tape_error), 32'd0);
    reset_n = 1'b1;
    arm = 1'b0;
    send(dstart + 2, dstart + 3);
    end_img();
    chk("idle_ignores_nonrestart", 32'(nwr), 32'd1);
    chk("idle_no_error_on_drop", 32'(tape_error), 32'd0);
    arm = 1'b1;

    // Single byte at the top of memory
    nwr = 0;
    build(16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 3, 1, 1);
    send(0, img.size());
    chk("top_complete", 32'(tape_complete), 32'd1);
    arm = 1'b0;
    img.push_back(8'h55);
    send(img.size() - 1, img.size());
    end_img();
    chk("top_nwr", 32'(nwr), 32'd1);
    chk("top_loadpoint", 32'(loadpoint), 32'hFFFF);
    chk("top_error", 32'(tape_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_loader.md
# tap_loader

Streaming parser for Oric `.TAP` cassette images, placed between the ioctl download channel and the tape write port of the 64 KiB dual-port RAM.
- Consumes downloaded image bytes one at a time and strips sync, header and filename.
- Writes the payload bytes to their load addresses.
- Publishes load point, autorun flag and a completion flag, which the machine core uses to start the program.
- Handles only the first file in an image.

## Interface
Parameters:
- MIN_SYNC, 3: minimum run of 0x16 sync bytes required before the 0x24 marker.
- MAX_NAME, 16: maximum filename length, not counting the 0x00 terminator.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- ioctl_download, in, 1: high while an image is being downloaded.
- ioctl_wr, in, 1: byte strobe; byte valid when ioctl_download & ioctl_wr.
- ioctl_addr, in, 25: offset of the byte within the image.
- ioctl_dout, in, 8: image byte.
- tape_addr, out, 16: RAM write address.
- tape_dout, out, 8: RAM write data.
- tape_wr, out, 1: single-cycle RAM write strobe.
- loadpoint, out, 16: program start address.
- tape_autorun, out, 1: header requested autorun.
- tape_type, out, 1: 1 = machine code (type byte bit 7), 0 = BASIC.
- tape_complete, out, 1: payload fully written.
- tape_error, out, 1: malformed or truncated image.

## Operation
- Accepted byte: a cycle with ioctl_download=1 and ioctl_wr=1. At most one byte is consumed per cycle. There is no back-pressure.
- Restart: an accepted byte with ioctl_addr==0 restarts the parser, even mid-file.
  - Clears tape_complete, tape_error, tape_autorun and all counters.
  - That byte is then processed in SYNC.
- States:
  - IDLE (reset state): accepts only a restart.
  - SYNC:
    - 0x16 increments sync_cnt, saturating at 7.
    - 0x24 with sync_cnt >= MIN_SYNC moves to HDR.
    - 0x24 with sync_cnt < MIN_SYNC, or any other byte, clears sync_cnt and stays in SYNC.
  - HDR: receives 9 bytes by index.
    - Bytes 0–1: ignored.
    - Byte 2: type.
    - Byte 3: autorun; nonzero means autorun.
    - Bytes 4–5: end address, high then low.
    - Bytes 6–7: start address, high then low.
    - Byte 8: ignored.
    - After byte 8: go to ERR if end < start, else go to NAME.
  - NAME:
    - 0x00 moves to DATA, with wptr = start.
    - Any other byte increments name_cnt.
    - A non-zero byte arriving when name_cnt == MAX_NAME moves to ERR.
  - DATA:
    - Each byte is written to wptr.
    - If wptr == end, go to DONE; otherwise wptr++.
    - The compare happens before the increment, so end = 0xFFFF does not wrap.
  - DONE:
    - tape_complete=1, loadpoint=start, tape_autorun and tape_type latched from the header.
    - Further bytes are ignored, so only the first file is loaded.
  - ERR:
    - tape_error=1, tape_complete=0, no writes.
    - Exits only by restart or reset.
- Falling edge of ioctl_download in SYNC, HDR, NAME or DATA moves to ERR.
  - A simultaneous accepted byte is processed first.
- A restart and a falling edge in the same cycle: the restart wins.

## Timing
- Reset values:
  - tape_addr=0, tape_dout=0, tape_wr=0, loadpoint=0.
  - tape_autorun=0, tape_type=0, tape_complete=0, tape_error=0.
  - State IDLE.
- Write latency: an accepted DATA byte in cycle N gives tape_wr=1 with registered tape_addr/tape_dout in cycle N+1. tape_wr is low in every other cycle.
- tape_complete rises in the same cycle as the final tape_wr, i.e. N+1 of the last byte. It is a level, held until restart or reset.
- loadpoint and tape_autorun are valid whenever tape_complete=1. They are stable from the cycle they are latched.
- tape_error is asserted in the cycle after the offending byte or edge. It is a level.
- Back-to-back accepted bytes, one per cycle, are sustained indefinitely.
- Reset asserted mid-DATA: the next cycle has tape_wr=0 and returns to IDLE. No partial-state outputs remain.

## Structure
- Package tap_pkg:
  - State enum: IDLE, SYNC, HDR, NAME, DATA, DONE, ERR.
  - Constants: TAP_SYNC=8'h16, TAP_MARK=8'h24, TAP_HDR_LEN=9.
  - Header field indices.
- Single flat module, no sub-module.
  - ioctl_download edge detection uses a one-flop delay held inside the module.

## Test plan
- Basic load: image 16 16 16 24 00 00 00 C7 05 03 05 00 00 'A' 00 AA BB CC DD, i.e. start 0x0500, end 0x0503.
  - Expect writes 0500=AA, 0501=BB, 0502=CC, 0503=DD.
  - Expect tape_complete=1, loadpoint=0500, tape_autorun=1, tape_type=0.
- Short sync: only two 0x16 before 0x24, then a valid sequence with 3 sync bytes.
  - First marker ignored; load succeeds from the second.
- Bad header: end 0x0400 < start 0x0500.
  - tape_error=1, zero tape_wr pulses.
- Long name: 17 non-zero name bytes.
  - ERR on the 17th byte; 16 bytes plus 0x00 loads normally.
- Truncation: ioctl_download drops after 2 of 4 data bytes.
  - Exactly 2 writes, then tape_error=1, tape_complete=0.
- Restart/reset: a new image starting at ioctl_addr=0 mid-DATA restarts cleanly and loads the second image. reset_n low mid-DATA clears all outputs next cycle. Start=end=0xFFFF writes one byte and completes.
